// File: rtl/axi_rd_arbiter.sv
// N-to-1 AXI read arbiter: one outstanding burst, registered AR, zero-latency R routing.
// Define AXI_RD_ARB_RR_EN for round-robin priority; otherwise fixed priority (port 0 highest).
module axi_rd_arbiter #(
  parameter int S_COUNT    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  localparam int AR_W = ID_WIDTH + ADDR_WIDTH + 13,
  localparam int R_W  = ID_WIDTH + DATA_WIDTH + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [S_COUNT*AR_W-1:0] s_axi_ar,
  input  logic [S_COUNT-1:0]     s_axi_arvalid,
  output logic [S_COUNT-1:0]     s_axi_arready,
  output logic [R_W-1:0]         s_axi_r,
  output logic [S_COUNT-1:0]     s_axi_rlast,
  output logic [S_COUNT-1:0]     s_axi_rvalid,
  input  logic [S_COUNT-1:0]     s_axi_rready,
  output logic [AR_W-1:0]        m_axi_ar,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  input  logic [R_W-1:0]         m_axi_r,
  input  logic                   m_axi_rlast,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready,
  output logic [S_COUNT-1:0]     grant,
  output logic                   len_err
);
  localparam int PW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t            r_state, w_state_nxt;
  logic [AR_W-1:0]   r_ar;
  logic              r_arvalid;
  logic [S_COUNT-1:0] r_grant;
  logic [7:0]        r_cnt;
  logic              r_len_err;

  logic [AR_W-1:0]   w_ar_arr [S_COUNT];
  logic [AR_W-1:0]   w_pay;
  logic [PW-1:0]     w_idx, w_cand;
  logic              w_found;
  logic [S_COUNT-1:0] w_sel, w_arready;
  logic              w_take, w_last, w_data, w_beat;

  for (genvar g = 0; g < S_COUNT; g++) begin : g_ar
    assign w_ar_arr[g] = s_axi_ar[g*AR_W +: AR_W];
  end

`ifdef AXI_RD_ARB_RR_EN
  logic [PW-1:0] r_ptr, r_gidx;

  // Pointer moves past the owner only once its burst has fully drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_gidx <= '0;
    end else begin
      if (w_take) r_gidx <= w_idx;
      if (w_last) r_ptr <= (r_gidx == PW'(S_COUNT-1)) ? '0 : r_gidx + PW'(1);
    end
  end
`endif

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int k = 0; k < S_COUNT; k++) begin
`ifdef AXI_RD_ARB_RR_EN
      w_cand = PW'((int'(r_ptr) + k) % S_COUNT);
`else
      w_cand = PW'(k);
`endif
      if (!w_found && s_axi_arvalid[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  assign w_sel  = w_found ? (S_COUNT'(1) << w_idx) : '0;
  assign w_pay  = w_ar_arr[w_idx];
  assign w_data = (r_state == S_DATA) && !rst;
  assign w_beat = m_axi_rvalid && m_axi_rready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arready   = '0;
    w_take      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: if (w_found) begin
        w_arready   = w_sel;
        w_take      = 1'b1;
        w_state_nxt = S_ADDR;
      end
      S_ADDR: if (m_axi_arready) w_state_nxt = S_DATA;
      S_DATA: if (w_beat && m_axi_rlast) begin
        w_last      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Length check: arlen lives at bits [12:5] of the captured AR payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ar      <= '0;
      r_arvalid <= 1'b0;
      r_grant   <= '0;
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      if (w_take) begin
        r_ar      <= w_pay;
        r_arvalid <= 1'b1;
        r_grant   <= w_sel;
      end
      if (r_state == S_ADDR && m_axi_arready) begin
        r_arvalid <= 1'b0;
        r_cnt     <= '0;
      end
      if (w_beat) begin
        r_cnt     <= r_cnt + 8'd1;
        r_len_err <= m_axi_rlast ? (r_cnt != r_ar[12:5]) : (r_cnt == r_ar[12:5]);
      end
      if (w_last) r_grant <= '0;
    end
  end

  assign s_axi_arready = rst ? '0 : w_arready;
  assign s_axi_r       = m_axi_r;
  assign s_axi_rvalid  = w_data ? (r_grant & {S_COUNT{m_axi_rvalid}}) : '0;
  assign s_axi_rlast   = w_data ? (r_grant & {S_COUNT{m_axi_rlast}}) : '0;
  assign m_axi_rready  = w_data && |(r_grant & s_axi_rready);
  assign m_axi_ar      = r_ar;
  assign m_axi_arvalid = r_arvalid;
  assign grant         = r_grant;
  assign len_err       = r_len_err;
endmodule
